// File: rtl/m68k_bus_arbiter.sv
// 68000 bus arbiter: shares the bus between the Pi-driven bus-cycle engine
// and external BR/BG/BGACK masters, with a guaranteed engine slot after each
// tenure, grant-timeout recovery and saturating grant statistics.
module m68k_bus_arbiter #(
    parameter int GRANT_TIMEOUT = 16,
    parameter int CPU_SLOT      = 4,
    parameter int CNT_W         = 8
) (
    input  logic             M68K_CLK,
    input  logic             M68K_RESET_n,
    input  logic             M68K_BR_n,
    input  logic             M68K_BGACK_n,
    input  logic             eng_idle,
    input  logic             clr_status,
    output logic             M68K_BG_n,
    output logic             eng_hold,
    output logic             dma_active,
    output logic [CNT_W-1:0] grant_count,
    output logic             timeout_flag
);

    localparam int TW        = (GRANT_TIMEOUT > 2) ? $clog2(GRANT_TIMEOUT) : 1;
    localparam int SW        = (CPU_SLOT > 2) ? $clog2(CPU_SLOT) : 1;
    localparam int SLOT_LAST = (CPU_SLOT > 0) ? CPU_SLOT - 1 : 0;

    typedef enum logic [2:0] {
        S_IDLE,
        S_HOLD,
        S_GRANT,
        S_OWNED,
        S_COOL
    } state_t;

    state_t         state;
    logic [TW-1:0]  timer;
    logic [SW-1:0]  slot;
    logic [1:0]     br_sync;
    logic [1:0]     bgack_sync;
    logic           br_s;
    logic           bgack_s;

    assign br_s    = ~br_sync[1];
    assign bgack_s = ~bgack_sync[1];

    // Two-flop synchronisers for the asynchronous active-low bus inputs.
    always_ff @(posedge M68K_CLK or negedge M68K_RESET_n) begin
        if (!M68K_RESET_n) begin
            br_sync    <= 2'b11;
            bgack_sync <= 2'b11;
        end else begin
            br_sync    <= {br_sync[0], M68K_BR_n};
            bgack_sync <= {bgack_sync[0], M68K_BGACK_n};
        end
    end

    // Arbitration FSM; every output is registered alongside the state.
    always_ff @(posedge M68K_CLK or negedge M68K_RESET_n) begin
        if (!M68K_RESET_n) begin
            state        <= S_IDLE;
            M68K_BG_n    <= 1'b1;
            eng_hold     <= 1'b0;
            dma_active   <= 1'b0;
            grant_count  <= '0;
            timeout_flag <= 1'b0;
            timer        <= '0;
            slot         <= '0;
        end else begin
            // A timeout set later in this block overrides the clear.
            if (clr_status) timeout_flag <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (br_s) begin
                        state    <= S_HOLD;
                        eng_hold <= 1'b1;
                    end
                end
                S_HOLD: begin
                    if (!br_s) begin
                        state    <= S_IDLE;
                        eng_hold <= 1'b0;
                    end else if (eng_idle) begin
                        state     <= S_GRANT;
                        M68K_BG_n <= 1'b0;
                        timer     <= '0;
                    end
                end
                S_GRANT: begin
                    if (bgack_s) begin
                        state      <= S_OWNED;
                        M68K_BG_n  <= 1'b1;
                        dma_active <= 1'b1;
                        if (grant_count != '1) grant_count <= grant_count + 1'b1;
                    end else if (!br_s) begin
                        state     <= S_IDLE;
                        M68K_BG_n <= 1'b1;
                        eng_hold  <= 1'b0;
                    end else if (timer == TW'(GRANT_TIMEOUT - 1)) begin
                        state        <= (CPU_SLOT == 0) ? S_IDLE : S_COOL;
                        M68K_BG_n    <= 1'b1;
                        eng_hold     <= 1'b0;
                        timeout_flag <= 1'b1;
                        slot         <= '0;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                S_OWNED: begin
                    if (!bgack_s) begin
                        state      <= (CPU_SLOT == 0) ? S_IDLE : S_COOL;
                        dma_active <= 1'b0;
                        eng_hold   <= 1'b0;
                        slot       <= '0;
                    end
                end
                S_COOL: begin
                    // Engine-only window: bus requests are not looked at here.
                    if (slot == SW'(SLOT_LAST)) state <= S_IDLE;
                    else                        slot  <= slot + 1'b1;
                end
                default: begin
                    state     <= S_IDLE;
                    M68K_BG_n <= 1'b1;
                    eng_hold  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_m68k_bus_arbiter.sv
// Self-checking bench for m68k_bus_arbiter: directed bus scenarios with
// literal expectations, then randomized traffic, with three DUT variants
// checked every cycle against a phase-level behavioural model.
module tb_m68k_bus_arbiter;

    localparam int P_IDLE  = 0;
    localparam int P_HOLD  = 1;
    localparam int P_GRANT = 2;
    localparam int P_OWNED = 3;
    localparam int P_COOL  = 4;

    typedef struct {
        int ph;
        int tmr;
        int slot;
        int cnt;
        bit flag;
        bit br_d0, br_d1;
        bit ack_d0, ack_d1;
    } mdl_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic br_n = 1'b1;
    logic bgack_n = 1'b1;
    logic eng_idle = 1'b1;
    logic clr = 1'b0;

    logic bg1, hold1, dma1, flag1;
    logic bg2, hold2, dma2, flag2;
    logic bg3, hold3, dma3, flag3;
    logic [7:0] cnt1;
    logic [1:0] cnt2;
    logic [3:0] cnt3;

    int n_tests = 0;
    int n_fail  = 0;
    mdl_t m1, m3;

    always #5 clk = ~clk;

    m68k_bus_arbiter #(.GRANT_TIMEOUT(16), .CPU_SLOT(4), .CNT_W(8)) dut1 (
        .M68K_CLK(clk), .M68K_RESET_n(rst_n), .M68K_BR_n(br_n), .M68K_BGACK_n(bgack_n),
        .eng_idle(eng_idle), .clr_status(clr), .M68K_BG_n(bg1), .eng_hold(hold1),
        .dma_active(dma1), .grant_count(cnt1), .timeout_flag(flag1));

    m68k_bus_arbiter #(.GRANT_TIMEOUT(16), .CPU_SLOT(4), .CNT_W(2)) dut2 (
        .M68K_CLK(clk), .M68K_RESET_n(rst_n), .M68K_BR_n(br_n), .M68K_BGACK_n(bgack_n),
        .eng_idle(eng_idle), .clr_status(clr), .M68K_BG_n(bg2), .eng_hold(hold2),
        .dma_active(dma2), .grant_count(cnt2), .timeout_flag(flag2));

    m68k_bus_arbiter #(.GRANT_TIMEOUT(5), .CPU_SLOT(0), .CNT_W(4)) dut3 (
        .M68K_CLK(clk), .M68K_RESET_n(rst_n), .M68K_BR_n(br_n), .M68K_BGACK_n(bgack_n),
        .eng_idle(eng_idle), .clr_status(clr), .M68K_BG_n(bg3), .eng_hold(hold3),
        .dma_active(dma3), .grant_count(cnt3), .timeout_flag(flag3));

    function automatic mdl_t mdl_reset();
        mdl_t m;
        m.ph = P_IDLE; m.tmr = 0; m.slot = 0; m.cnt = 0; m.flag = 1'b0;
        m.br_d0 = 1'b1; m.br_d1 = 1'b1; m.ack_d0 = 1'b1; m.ack_d1 = 1'b1;
        return m;
    endfunction

    // One bus clock of the arbitration rules; requests seen two clocks late.
    function automatic mdl_t mdl_step(mdl_t mi, bit b_n, bit a_n, bit idle, bit c,
                                      int slots, int tmo);
        mdl_t m = mi;
        bit br = !mi.br_d1;
        bit ack = !mi.ack_d1;
        bit set = 1'b0;
        case (mi.ph)
            P_IDLE:  if (br) m.ph = P_HOLD;
            P_HOLD:  if (!br) m.ph = P_IDLE;
                     else if (idle) begin m.ph = P_GRANT; m.tmr = 0; end
            P_GRANT: if (ack) begin m.ph = P_OWNED; m.cnt = mi.cnt + 1; end
                     else if (!br) m.ph = P_IDLE;
                     else if (mi.tmr == tmo - 1) begin
                         set = 1'b1; m.slot = 0;
                         m.ph = (slots == 0) ? P_IDLE : P_COOL;
                     end else m.tmr = mi.tmr + 1;
            P_OWNED: if (!ack) begin m.slot = 0; m.ph = (slots == 0) ? P_IDLE : P_COOL; end
            default: if (mi.slot == slots - 1) m.ph = P_IDLE; else m.slot = mi.slot + 1;
        endcase
        m.flag = set ? 1'b1 : (c ? 1'b0 : mi.flag);
        m.br_d1 = mi.br_d0; m.br_d0 = b_n;
        m.ack_d1 = mi.ack_d0; m.ack_d0 = a_n;
        return m;
    endfunction

    // Reference model advances on the same edges as the DUTs.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m1 <= mdl_reset();
            m3 <= mdl_reset();
        end else begin
            m1 <= mdl_step(m1, br_n, bgack_n, eng_idle, clr, 4, 16);
            m3 <= mdl_step(m3, br_n, bgack_n, eng_idle, clr, 0, 5);
        end
    end

    task automatic cmp_inst(input string nm, input bit bg, input bit hd, input bit dm,
                            input int cnt, input bit fl, input mdl_t m, input int w);
        int  sat = (1 << w) - 1;
        int  ecnt = (m.cnt > sat) ? sat : m.cnt;
        bit  ebg = (m.ph != P_GRANT);
        bit  ehd = (m.ph == P_HOLD) || (m.ph == P_GRANT) || (m.ph == P_OWNED);
        bit  edm = (m.ph == P_OWNED);
        n_tests++;
        if (bg !== ebg || hd !== ehd || dm !== edm || cnt != ecnt || fl !== m.flag) begin
            n_fail++;
            if (n_fail < 20)
                $display("FAIL %s @%0t: got bg=%b hold=%b dma=%b cnt=%0d flag=%b, want bg=%b hold=%b dma=%b cnt=%0d flag=%b",
                         nm, $time, bg, hd, dm, cnt, fl, ebg, ehd, edm, ecnt, m.flag);
        end
    endtask

    // Every cycle, all three variants against the model, away from the edge.
    always @(posedge clk) begin
        #2;
        cmp_inst("model_dut1", bg1, hold1, dma1, int'(cnt1), flag1, m1, 8);
        cmp_inst("model_dut2", bg2, hold2, dma2, int'(cnt2), flag2, m1, 2);
        cmp_inst("model_dut3", bg3, hold3, dma3, int'(cnt3), flag3, m3, 4);
    end

    task automatic chk(input string nm, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, want %0d", nm, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #4;
    endtask

    // Waits for dut1 signal 'which' (0=BG_n, 1=dma_active) to reach val.
    task automatic wait_for(input string nm, input int which, input bit val, input int max);
        bit got = 1'b0;
        for (int i = 0; i < max && !got; i++) begin
            tick(1);
            got = ((which == 0) ? bg1 : dma1) == val;
        end
        chk(nm, int'(got), 1);
    endtask

    int bg_low;
    int ack_left;
    bit seen;

    initial begin
        // Reset held with a pending request.
        br_n = 1'b0;
        tick(3);
        chk("rst_bg", bg1, 1);
        chk("rst_hold", hold1, 0);
        chk("rst_dma", dma1, 0);
        chk("rst_cnt", cnt1, 0);
        chk("rst_flag", flag1, 0);
        rst_n = 1'b1;
        tick(2);
        chk("hold_before_sync", hold1, 0);
        tick(1);
        chk("hold_after_3", hold1, 1);
        tick(1);
        chk("bg_after_hold", bg1, 0);

        // Acknowledge and tenure.
        bgack_n = 1'b0;
        tick(2);
        chk("dma_sync_wait", dma1, 0);
        tick(1);
        chk("dma_on", dma1, 1);
        chk("bg_off_owned", bg1, 1);
        chk("cnt_one", cnt1, 1);
        bgack_n = 1'b1;
        tick(2);
        chk("dma_still", dma1, 1);
        tick(1);
        chk("dma_off", dma1, 0);
        chk("cool_hold0", hold1, 0);
        for (int i = 0; i < 3; i++) begin
            tick(1);
            chk("cool_ignores_br", hold1, 0);
        end
        tick(1);
        chk("idle_after_cool", hold1, 0);
        tick(1);
        chk("rearb_hold", hold1, 1);

        // Timeout: nobody acknowledges.
        bg_low = 0;
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            tick(1);
            if (bg1 == 1'b0) bg_low++;
            else if (bg_low > 0) seen = 1'b1;
        end
        chk("timeout_bg_low_len", bg_low, 16);
        chk("timeout_flag_set", flag1, 1);
        chk("timeout_cnt_same", cnt1, 1);
        br_n = 1'b1;
        clr = 1'b1;
        tick(1);
        clr = 1'b0;
        chk("flag_cleared", flag1, 0);

        // Timeout while clear is held: set wins for that clock.
        tick(8);
        br_n = 1'b0;
        clr = 1'b1;
        wait_for("sim_grant", 0, 1'b0, 20);
        wait_for("sim_timeout", 0, 1'b1, 40);
        chk("set_beats_clear", flag1, 1);
        tick(1);
        chk("clear_next", flag1, 0);
        clr = 1'b0;
        br_n = 1'b1;
        tick(10);

        // Busy engine.
        eng_idle = 1'b0;
        br_n = 1'b0;
        tick(10);
        chk("busy_bg", bg1, 1);
        chk("busy_hold", hold1, 1);
        eng_idle = 1'b1;
        tick(1);
        chk("busy_release_bg", bg1, 0);

        // Withdraw in GRANT.
        br_n = 1'b1;
        tick(3);
        chk("withdraw_bg", bg1, 1);
        chk("withdraw_hold", hold1, 0);
        chk("withdraw_flag", flag1, 0);
        chk("withdraw_cnt", cnt1, 1);

        // Request pulse during HOLD.
        eng_idle = 1'b0;
        br_n = 1'b0;
        tick(4);
        chk("pulse_hold", hold1, 1);
        br_n = 1'b1;
        tick(3);
        chk("pulse_back_idle", hold1, 0);
        eng_idle = 1'b1;
        tick(2);

        // Five tenures: narrow counter saturates.
        for (int t = 0; t < 5; t++) begin
            br_n = 1'b0;
            wait_for("sat_grant", 0, 1'b0, 20);
            bgack_n = 1'b0;
            wait_for("sat_owned", 1, 1'b1, 10);
            br_n = 1'b1;
            bgack_n = 1'b1;
            tick(10);
        end
        chk("cnt_wide", cnt1, 6);
        chk("cnt_saturated", cnt2, 3);

        // Reset mid-tenure.
        br_n = 1'b0;
        wait_for("abort_grant", 0, 1'b0, 20);
        bgack_n = 1'b0;
        wait_for("abort_owned", 1, 1'b1, 10);
        rst_n = 1'b0;
        #1;
        chk("abort_bg", bg1, 1);
        chk("abort_hold", hold1, 0);
        chk("abort_dma", dma1, 0);
        chk("abort_cnt", cnt1, 0);
        chk("abort_cnt2", cnt2, 0);
        tick(2);
        br_n = 1'b1;
        bgack_n = 1'b1;
        rst_n = 1'b1;
        tick(2);

        // Randomized traffic with a loosely behaved external master.
        ack_left = 0;
        for (int c = 0; c < 3000; c++) begin
            tick(1);
            if (!(eng_idle && (m1.ph != P_IDLE || m3.ph != P_IDLE)))
                eng_idle = ($urandom_range(0, 3) != 0);
            clr = ($urandom_range(0, 15) == 0);
            if (ack_left > 0) begin
                ack_left--;
                if (ack_left == 0) begin
                    bgack_n = 1'b1;
                    br_n = $urandom_range(0, 1);
                end
            end else if ((m1.ph == P_GRANT || m3.ph == P_GRANT) && $urandom_range(0, 9) < 6) begin
                bgack_n = 1'b0;
                ack_left = $urandom_range(1, 8);
            end else if ($urandom_range(0, 7) == 0) begin
                br_n = ~br_n;
            end
            if ($urandom_range(0, 499) == 0) begin
                rst_n = 1'b0;
                tick(1);
                rst_n = 1'b1;
                bgack_n = 1'b1;
                ack_left = 0;
            end
        end
        tick(2);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
